// File: rtl/sar_searcher_pkg.sv
// Shared definitions for the successive-approximation searcher.
// Optional one-hot flag check is enabled with `define CMP_ONEHOT_CHECK_EN.
package sar_searcher_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRIAL  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_CMP_LAT = 1;

    // True when exactly one of the three comparator flags is set.
    function automatic logic onehot3(input logic a, input logic b, input logic c);
        return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
    endfunction

endpackage

// File: rtl/sar_wait_counter.sv
// Counts CMP_LAT edges after each guess update; decide marks the edge on which
// the comparator flags reflect the current guess.
module sar_wait_counter
    import sar_searcher_pkg::*;
#(
    parameter int CMP_LAT = DEF_CMP_LAT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic decide
);

    localparam int CW = (CMP_LAT > 0) ? $clog2(CMP_LAT + 1) : 1;

    logic [CW-1:0] wcnt;

    assign decide = en && (wcnt == CW'(CMP_LAT));

    always_ff @(posedge clk) begin
        if (!rst)
            wcnt <= '0;
        else if (clear)
            wcnt <= '0;
        else if (en)
            wcnt <= wcnt + CW'(1);
    end

endmodule

// File: rtl/sar_searcher.sv
// MSB-first successive-approximation search against a registered comparator.
// `define CMP_ONEHOT_CHECK_EN adds the sticky err output for non-one-hot flags.
module sar_searcher
    import sar_searcher_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CMP_LAT = DEF_CMP_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_equal,
    input  logic             cmp_less,
    input  logic             cmp_greater,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found
`ifdef CMP_ONEHOT_CHECK_EN
    ,
    output logic             err
`endif
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [IW-1:0]    bidx;
    logic             decide;
    logic             wclr;
    logic             wen;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] next_mask;
    logic [WIDTH-1:0] kept;

    assign wen  = (state == TRIAL) || (state == VERIFY);
    assign wclr = ((state == IDLE) && start) || decide;

    sar_wait_counter #(.CMP_LAT(CMP_LAT)) u_wait (
        .clk    (clk),
        .rst    (rst),
        .clear  (wclr),
        .en     (wen),
        .decide (decide)
    );

    // greater outranks less, so only greater clears the bit under test
    assign bit_mask  = WIDTH'(1) << bidx;
    assign next_mask = bit_mask >> 1;
    assign kept      = cmp_greater ? (guess & ~bit_mask) : guess;

`ifndef CMP_ONEHOT_CHECK_EN
    // less is implied by the absence of greater; it only matters to the flag check
    logic unused_less;
    assign unused_less = cmp_less;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            guess  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            found  <= 1'b0;
            bidx   <= IW'(WIDTH - 1);
`ifdef CMP_ONEHOT_CHECK_EN
            err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        guess <= WIDTH'(1) << (WIDTH - 1);
                        bidx  <= IW'(WIDTH - 1);
                        found <= 1'b0;
                        busy  <= 1'b1;
                        state <= TRIAL;
`ifdef CMP_ONEHOT_CHECK_EN
                        err   <= 1'b0;
`endif
                    end
                end
                TRIAL: begin
                    if (decide) begin
`ifdef CMP_ONEHOT_CHECK_EN
                        if (!onehot3(cmp_equal, cmp_less, cmp_greater))
                            err <= 1'b1;
`endif
                        if (cmp_equal) begin
                            result <= guess;
                            found  <= 1'b1;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else if (bidx != '0) begin
                            guess <= kept | next_mask;
                            bidx  <= bidx - IW'(1);
                        end else begin
                            guess <= kept;
                            state <= VERIFY;
                        end
                    end
                end
                VERIFY: begin
                    if (decide) begin
`ifdef CMP_ONEHOT_CHECK_EN
                        if (!onehot3(cmp_equal, cmp_less, cmp_greater))
                            err <= 1'b1;
`endif
                        result <= guess;
                        found  <= cmp_equal;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
